// File: rtl/data_mem_sync_if.sv
// Request/response bundle between the datapath and data_mem_sync.
// The requester drives the access fields; the memory returns load data, ready and the misalignment pulse.
interface data_mem_sync_if #(
    parameter int ADDR_W = 9
);
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic              sign_ext;
    logic [31:0]       write_data;
    logic [31:0]       read_data;
    logic              read_valid;
    logic              ready;
    logic              misaligned;

    modport master (
        output MemRead, MemWrite, addr, size, sign_ext, write_data,
        input  read_data, read_valid, ready, misaligned
    );

    modport slave (
        input  MemRead, MemWrite, addr, size, sign_ext, write_data,
        output read_data, read_valid, ready, misaligned
    );
endinterface

// File: rtl/data_mem_sync.sv
// Byte/half/word data memory: single-cycle writes, reads return after RD_LAT cycles.
// ready is low while a read is in flight; requests seen then are dropped, not queued.
module data_mem_sync #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_sync_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [1:0]       cnt, cnt_nxt;
    logic             accept;
    logic             aligned;
    logic             wr_go, rd_go, mis_go;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      wdat;
    logic [31:0]      cap_word;
    logic [1:0]       cap_off;
    logic [1:0]       cap_size;
    logic             cap_sext;
    logic [31:0]      rd_q;
    logic             mis_q;

    // Zeroed once at power-up only; reset deliberately leaves contents alone.
    logic [31:0] mem [DEPTH] = '{default: '0};

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] sz, input logic se);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   return se ? {{24{b[7]}}, b} : {24'h0, b};
            2'b01:   return se ? {{16{h[15]}}, h} : {16'h0, h};
            default: return w;
        endcase
    endfunction

    assign idx    = bus.addr[IDX_W+1:2];
    assign accept = (state == IDLE);

    always_comb begin
        aligned = 1'b1;
        case (bus.size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~bus.addr[0];
            default: aligned = (bus.addr[1:0] == 2'b00);
        endcase
    end

    // A simultaneous read+write resolves to the write alone.
    assign wr_go  = accept & bus.MemWrite & aligned;
    assign rd_go  = accept & bus.MemRead & ~bus.MemWrite & aligned;
    assign mis_go = accept & (bus.MemRead | bus.MemWrite) & ~aligned;

    always_comb begin
        be   = 4'b1111;
        wdat = bus.write_data;
        case (bus.size)
            2'b00: begin
                be   = 4'b0001 << bus.addr[1:0];
                wdat = {4{bus.write_data[7:0]}};
            end
            2'b01: begin
                be   = bus.addr[1] ? 4'b1100 : 4'b0011;
                wdat = {2{bus.write_data[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wdat = bus.write_data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_go && be[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        bus.ready      = 1'b0;
        bus.read_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (rd_go) begin
                    state_nxt = BUSY;
                    cnt_nxt   = 2'(RD_LAT - 1);
                end
            end
            BUSY: begin
                if (cnt == 2'd0) begin
                    bus.read_valid = 1'b1;
                    state_nxt      = IDLE;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Load data is registered on the edge that enters the read_valid cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_word <= 32'h0;
            cap_off  <= 2'b00;
            cap_size <= 2'b00;
            cap_sext <= 1'b0;
            rd_q     <= 32'h0;
            mis_q    <= 1'b0;
        end else begin
            mis_q <= mis_go;
            if (rd_go) begin
                cap_word <= mem[idx];
                cap_off  <= bus.addr[1:0];
                cap_size <= bus.size;
                cap_sext <= bus.sign_ext;
                if (RD_LAT == 1) rd_q <= extend(mem[idx], bus.addr[1:0], bus.size, bus.sign_ext);
            end
            if (state == BUSY && cnt == 2'd1) begin
                rd_q <= extend(cap_word, cap_off, cap_size, cap_sext);
            end
        end
    end

    assign bus.read_data  = rd_q;
    assign bus.misaligned = mis_q;
endmodule

// File: tb/tb_data_mem_sync.sv
// Scoreboard bench for data_mem_sync: one instance with RD_LAT=1, one with RD_LAT=3.
module tb_data_mem_sync;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    data_mem_sync_if #(.ADDR_W(10)) b1 ();
    data_mem_sync_if #(.ADDR_W(10)) b3 ();

    data_mem_sync #(.DEPTH(128), .ADDR_W(10), .RD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    data_mem_sync #(.DEPTH(128), .ADDR_W(10), .RD_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    int checks   = 0;
    int failures = 0;
    logic [31:0] q1[$];
    logic [31:0] q3[$];
    logic [7:0]  mb[512];

    function automatic logic rv(int d);   return (d == 1) ? b1.read_valid : b3.read_valid; endfunction
    function automatic logic rdy(int d);  return (d == 1) ? b1.ready      : b3.ready;      endfunction
    function automatic logic mis(int d);  return (d == 1) ? b1.misaligned : b3.misaligned; endfunction
    function automatic logic [31:0] rdat(int d); return (d == 1) ? b1.read_data : b3.read_data; endfunction

    task automatic drive(int d, logic rd, logic wr, logic [9:0] a, logic [1:0] sz, logic se, logic [31:0] wd);
        if (d == 1) begin
            b1.MemRead = rd; b1.MemWrite = wr; b1.addr = a; b1.size = sz; b1.sign_ext = se; b1.write_data = wd;
        end else begin
            b3.MemRead = rd; b3.MemWrite = wr; b3.addr = a; b3.size = sz; b3.sign_ext = se; b3.write_data = wd;
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents one request for exactly one edge; returns at the following negedge.
    task automatic issue(int d, logic rd, logic wr, logic [9:0] a, logic [1:0] sz, logic se, logic [31:0] wd);
        drive(d, rd, wr, a, sz, se, wd);
        step();
        drive(d, 1'b0, 1'b0, 10'h0, 2'b00, 1'b0, 32'h0);
    endtask

    task automatic do_read(int d, logic [9:0] a, logic [1:0] sz, logic se, logic [31:0] exp, string name);
        int n;
        logic [31:0] e;
        if (d == 1) q1.push_back(exp); else q3.push_back(exp);
        issue(d, 1'b1, 1'b0, a, sz, se, 32'h0);
        n = 1;
        while (!rv(d) && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (!rv(d)) begin
            failures++;
            $display("FAIL %s_timeout read_valid=0 after %0d cycles, required a pulse", name, n);
            if (d == 1) void'(q1.pop_front()); else void'(q3.pop_front());
        end else begin
            if (d == 1) e = q1.pop_front(); else e = q3.pop_front();
            checks++;
            if (rdat(d) !== e) begin
                failures++;
                $display("FAIL %s_data got=%h required=%h", name, rdat(d), e);
            end
            checks++;
            if (n !== d) begin
                failures++;
                $display("FAIL %s_latency got=%0d required=%0d", name, n, d);
            end
        end
        step();
        checks++;
        if (rv(d) !== 1'b0 || rdy(d) !== 1'b1) begin
            failures++;
            $display("FAIL %s_after read_valid=%b ready=%b required read_valid=0 ready=1", name, rv(d), rdy(d));
        end
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(3, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 1; d <= 3; d += 2) begin
            checks++;
            if (rdy(d) !== 1'b1 || rv(d) !== 1'b0 || mis(d) !== 1'b0 || rdat(d) !== 32'h0) begin
                failures++;
                $display("FAIL reset_state dut%0d ready=%b read_valid=%b misaligned=%b read_data=%h required 1 0 0 0",
                         d, rdy(d), rv(d), mis(d), rdat(d));
            end
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_word_rw();
        issue(1, 0, 1, 10'h010, 2'b10, 0, 32'hDEADBEEF);
        checks++;
        if (rdy(1) !== 1'b1 || mis(1) !== 1'b0) begin
            failures++;
            $display("FAIL t1_write ready=%b misaligned=%b required 1 0", rdy(1), mis(1));
        end
        do_read(1, 10'h010, 2'b10, 0, 32'hDEADBEEF, "t1_word");
        checks++;
        if (rdat(1) !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL t1_hold got=%h required=deadbeef", rdat(1));
        end
    endtask

    task automatic test_subword();
        issue(1, 0, 1, 10'h013, 2'b00, 0, 32'h00000080);
        do_read(1, 10'h013, 2'b00, 1, 32'hFFFFFF80, "t2_byte_sext");
        do_read(1, 10'h013, 2'b00, 0, 32'h00000080, "t2_byte_zext");
        do_read(1, 10'h010, 2'b10, 0, 32'h80ADBEEF, "t2_word");
        issue(1, 0, 1, 10'h042, 2'b01, 0, 32'hFFFF8001);
        do_read(1, 10'h042, 2'b01, 1, 32'hFFFF8001, "half_sext");
        do_read(1, 10'h042, 2'b01, 0, 32'h00008001, "half_zext");
        do_read(1, 10'h040, 2'b10, 0, 32'h80010000, "half_lanes");
    endtask

    task automatic test_misaligned();
        issue(1, 0, 1, 10'h011, 2'b01, 0, 32'h0000FFFF);
        checks++;
        if (mis(1) !== 1'b1 || rdy(1) !== 1'b1) begin
            failures++;
            $display("FAIL t3_flag misaligned=%b ready=%b required 1 1", mis(1), rdy(1));
        end
        step();
        checks++;
        if (mis(1) !== 1'b0) begin
            failures++;
            $display("FAIL t3_pulse misaligned=%b required 0", mis(1));
        end
        do_read(1, 10'h010, 2'b10, 0, 32'h80ADBEEF, "t3_unchanged");
        issue(1, 1, 0, 10'h012, 2'b11, 0, 32'h0);
        checks++;
        if (mis(1) !== 1'b1 || rv(1) !== 1'b0) begin
            failures++;
            $display("FAIL rsvd_read misaligned=%b read_valid=%b required 1 0", mis(1), rv(1));
        end
        step();
    endtask

    task automatic test_latency3();
        logic [31:0] e;
        issue(3, 0, 1, 10'h020, 2'b10, 0, 32'hCAFEF00D);
        q3.push_back(32'hCAFEF00D);
        drive(3, 1, 0, 10'h020, 2'b10, 0, 32'h0);
        step();
        checks++;
        if (rdy(3) !== 1'b0 || rv(3) !== 1'b0) begin
            failures++;
            $display("FAIL t4_c1 ready=%b read_valid=%b required 0 0", rdy(3), rv(3));
        end
        drive(3, 0, 1, 10'h020, 2'b10, 0, 32'h11111111);
        step();
        drive(3, 0, 0, 10'h0, 2'b00, 0, 32'h0);
        checks++;
        if (rdy(3) !== 1'b0 || rv(3) !== 1'b0) begin
            failures++;
            $display("FAIL t4_c2 ready=%b read_valid=%b required 0 0", rdy(3), rv(3));
        end
        step();
        e = q3.pop_front();
        checks++;
        if (rdy(3) !== 1'b0 || rv(3) !== 1'b1 || rdat(3) !== e) begin
            failures++;
            $display("FAIL t4_c3 ready=%b read_valid=%b data=%h required 0 1 %h", rdy(3), rv(3), rdat(3), e);
        end
        step();
        checks++;
        if (rdy(3) !== 1'b1 || rv(3) !== 1'b0) begin
            failures++;
            $display("FAIL t4_idle ready=%b read_valid=%b required 1 0", rdy(3), rv(3));
        end
        do_read(3, 10'h020, 2'b10, 0, 32'hCAFEF00D, "t4_write_ignored");
    endtask

    task automatic test_reset_midread();
        logic seen;
        q3.push_back(32'hCAFEF00D);
        issue(3, 1, 0, 10'h020, 2'b10, 0, 32'h0);
        checks++;
        if (rdy(3) !== 1'b0) begin
            failures++;
            $display("FAIL t5_busy ready=%b required 0", rdy(3));
        end
        rst_n = 1'b0;
        q3.delete();
        #1;
        checks++;
        if (rdy(3) !== 1'b1 || rv(3) !== 1'b0 || rdat(3) !== 32'h0) begin
            failures++;
            $display("FAIL t5_reset ready=%b read_valid=%b data=%h required 1 0 0", rdy(3), rv(3), rdat(3));
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            step();
            if (rv(3)) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL t5_aborted read_valid seen=%b required 0", seen);
        end
        do_read(3, 10'h020, 2'b10, 0, 32'hCAFEF00D, "t5_mem_kept3");
        do_read(1, 10'h010, 2'b10, 0, 32'h80ADBEEF, "t5_mem_kept1");
    endtask

    task automatic test_wrap_and_collision();
        issue(1, 0, 1, 10'h000, 2'b10, 0, 32'h12345678);
        do_read(1, 10'h200, 2'b10, 0, 32'h12345678, "t6_wrap");
        issue(1, 1, 1, 10'h004, 2'b10, 0, 32'hA5A5A5A5);
        checks++;
        if (rdy(1) !== 1'b1 || rv(1) !== 1'b0 || mis(1) !== 1'b0) begin
            failures++;
            $display("FAIL t6_rdwr ready=%b read_valid=%b misaligned=%b required 1 0 0", rdy(1), rv(1), mis(1));
        end
        step();
        checks++;
        if (rv(1) !== 1'b0) begin
            failures++;
            $display("FAIL t6_rdwr_late read_valid=%b required 0", rv(1));
        end
        do_read(1, 10'h004, 2'b10, 0, 32'hA5A5A5A5, "t6_write_done");
    endtask

    task automatic test_back_to_back();
        issue(1, 0, 1, 10'h044, 2'b10, 0, 32'h0BADF00D);
        do_read(1, 10'h044, 2'b10, 0, 32'h0BADF00D, "b2b_fresh");
        issue(1, 0, 1, 10'h046, 2'b00, 0, 32'h000000EE);
        do_read(1, 10'h044, 2'b10, 0, 32'h0BEEF00D, "b2b_byte");
    endtask

    task automatic test_random();
        logic [1:0]  sz;
        logic [9:0]  a;
        logic        se, wr, al;
        logic [31:0] wd, exp;
        logic [15:0] hv;
        int ai;
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            a = 10'h180 + 10'(w * 4);
            issue(1, 0, 1, a, 2'b10, 0, wd);
            for (int k = 0; k < 4; k++) mb[int'(a) + k] = wd[8*k +: 8];
        end
        for (int i = 0; i < 40; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 10'h180 + 10'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz[1]) a[1:0] = 2'b00;
            end
            se = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            al = (sz == 2'b00) || (sz == 2'b01 && !a[0]) || (sz[1] && a[1:0] == 2'b00);
            ai = int'(a);
            if (wr || !al) begin
                issue(1, !wr, wr, a, sz, se, wd);
                checks++;
                if (mis(1) !== !al || rv(1) !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_flag addr=%h size=%0d misaligned=%b read_valid=%b required %b 0",
                             a, sz, mis(1), rv(1), !al);
                end
                if (wr && al) begin
                    mb[ai] = wd[7:0];
                    if (sz != 2'b00) mb[ai + 1] = wd[15:8];
                    if (sz[1]) begin
                        mb[ai + 2] = wd[23:16];
                        mb[ai + 3] = wd[31:24];
                    end
                end
            end else begin
                hv = {mb[ai + 1], mb[ai]};
                case (sz)
                    2'b00:   exp = se ? {{24{mb[ai][7]}}, mb[ai]} : {24'h0, mb[ai]};
                    2'b01:   exp = se ? {{16{hv[15]}}, hv} : {16'h0, hv};
                    default: exp = {mb[ai + 3], mb[ai + 2], mb[ai + 1], mb[ai]};
                endcase
                do_read(1, a, sz, se, exp, "rand_rd");
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_rw();
        test_subword();
        test_misaligned();
        test_latency3();
        test_reset_midread();
        test_wrap_and_collision();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
